mux4_rr_arbiter: RTL
====================

// Module: mux4_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one Mux4 datapath among 4 requesters.
//  - Drives the Mux4 sel_port so the granted requester's data reaches port_out.
//  - Grants are registered, one-hot, and fair; hold time per owner is bounded.
//  - Sits between the requesting units (e.g. regfile/ALU/imm/mem sources) and the Mux4.
// PARAMETERS
//  NUM_REQ   4  requester count; fixed at 4 to match Mux4 (not overridable in v1)
//  MAX_HOLD  4  max consecutive cycles one owner keeps the grant while others wait; legal range 1..15
// PORTS
//  clk        in   1  single clock; all state updates on posedge
//  rst        in   1  synchronous, active-high reset
//  req        in   4  req[k]=1: requester k wants the Mux4
//  gnt        out  4  one-hot grant, registered; all-zero when idle
//  sel_port   out  2  Mux4 select = index of current/last owner
//  bus_valid  out  1  1 while gnt != 0 (Mux4 output is owned and valid)
//  hold_cnt   out  4  cycles the current owner has held the grant, minus 1 (debug/verify)
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, gnt=0, sel_port=0, bus_valid=0, hold_cnt=0, ptr=0.
//   Reset overrides everything, including mid-grant.
//  ptr (2b): the index with highest priority. The search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
//  pick(mask): the first set bit of mask in that order. Used only when mask != 0.
//  FSM states: IDLE, GRANT. All transitions are evaluated on posedge using the req sampled that edge.
//  IDLE:
//   - req==0: stay in IDLE.
//   - req!=0: go to GRANT.
//     owner=pick(req); gnt=1<<owner; sel_port=owner; hold_cnt=0; ptr=owner+1.
//  GRANT (owner o):
//   - req[o]=0 and others=req&~(1<<o) != 0: hand over in the same edge, with no idle bubble.
//     New owner=pick(others); hold_cnt=0.
//   - req[o]=0 and others==0: go to IDLE. gnt=0; sel_port keeps o.
//   - req[o]=1, hold_cnt==MAX_HOLD-1, and others!=0: forced rotation.
//     New owner=pick(others); hold_cnt=0.
//   - req[o]=1, otherwise: keep o.
//     hold_cnt increments and saturates at MAX_HOLD-1 (it does not wrap when uncontended).
//   - On every new grant, ptr=new_owner+1 (mod 4). The 3->0 wrap is required.
//  Latency: req rising edge to gnt is 1 clock. Release is 1 clock.
//  sel_port changes only on a grant edge; it holds its value in IDLE to keep Mux4 output stable.
//  Invariants:
//   - gnt is always one-hot or zero.
//   - bus_valid == |gnt.
//   - gnt[sel_port]==1 whenever bus_valid.
//  MAX_HOLD=1: every contended cycle rotates; a sole requester keeps the grant indefinitely.
// STRUCTURE
//  Package cpu_arb_pkg:
//   - typedef enum logic {IDLE, GRANT} arb_state_t
//   - localparam NUM_REQ=4, SEL_W=2
//   - function rr_pick(logic[3:0] mask, logic[1:0] ptr) returning logic[1:0]
//  Sub-module rr_pick4 (combinational, 4-bit rotate -> priority encode -> un-rotate).
//   Instantiated once; the FSM and counters live in the top.
//  The Mux4 is instantiated by the parent, not inside this block.
// TESTING
//  Bench drives req on negedge, checks on the next negedge, and instantiates the Mux4 with data 0x11/0x22/0x33/0x44.
//  T1 reset:
//   - rst=1 for 2 clk with req=4'hF -> gnt=0, sel_port=0, bus_valid=0.
//   - Release rst -> next edge gnt=4'b0001, port_out=0x11.
//  T2 fairness:
//   - Hold req=4'hF, MAX_HOLD=1 -> gnt sequence 0001,0010,0100,1000,0001.
//   - sel_port sequence 0,1,2,3,0 (checks the wrap).
//  T3 hold limit:
//   - MAX_HOLD=4, req=4'b0011 continuous -> owner 0 for 4 cycles (hold_cnt 0..3), then owner 1 for 4, then 0.
//  T4 early release:
//   - Owner 2, req 4'b0100 -> 4'b1001 -> next edge gnt=1000 (ptr=3), no IDLE cycle.
//   - Then req=0 -> gnt=0, sel_port stays 3, port_out=0x44.
//  T5 uncontended:
//   - req=4'b0010 for 10 cycles -> gnt stays 0010 and hold_cnt saturates at 3.
//   - Then req=4'b0110 -> gnt=0100 after 1 clk.
//  T6 reset mid-grant:
//   - Owner 3, hold_cnt=2, rst pulse 1 clk with req=4'hA.
//   - -> gnt=0 during rst; next edge gnt=0010 (ptr back to 0).

Source files
------------

// File: rtl/cpu_arb_pkg.sv
// Shared types and helpers for the 4-way round-robin Mux4 arbiter.
package cpu_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    // Reference round-robin pick: first set bit of mask searching ptr, ptr+1,
    // ptr+2, ptr+3 (mod 4). Only meaningful when mask != 0.
    function automatic logic [1:0] rr_pick(input logic [3:0] mask, input logic [1:0] ptr);
        logic [1:0] idx;
        rr_pick = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (mask[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: rotate the mask so ptr sits at bit 0,
// priority-encode the lowest set bit, then add ptr back to un-rotate.
module rr_pick4
    import cpu_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_mask,
    input  logic [SEL_W-1:0]   i_ptr,
    output logic [SEL_W-1:0]   o_idx,
    output logic               o_any
);

    logic [NUM_REQ-1:0] w_rot;
    logic [SEL_W-1:0]   w_off;

    // Rotate so that requester ptr lands at position 0.
    always_comb begin
        w_rot = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_rot[k] = i_mask[i_ptr + 2'(k)];
        end
    end

    // Lowest set bit of the rotated mask is the closest requester after ptr.
    always_comb begin
        w_off = 2'd0;
        if (w_rot[0]) begin
            w_off = 2'd0;
        end else if (w_rot[1]) begin
            w_off = 2'd1;
        end else if (w_rot[2]) begin
            w_off = 2'd2;
        end else if (w_rot[3]) begin
            w_off = 2'd3;
        end
    end

    // Un-rotate: 2-bit addition wraps naturally mod 4.
    assign o_idx = i_ptr + w_off;
    assign o_any = |i_mask;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns the select of a shared Mux4. Grants are
// registered and one-hot; an owner is forced off after MAX_HOLD cycles when
// others are waiting. sel_port holds the last owner while idle so the Mux4
// output stays stable. MAX_HOLD legal range is 1..15.
//
// Handshake: req[k] is a level request sampled every posedge; gnt[k] rises one
// clock after req[k] is seen and the owner keeps it until it drops req, is
// rotated out, or rst is asserted. There is no separate ack.
module mux4_rr_arbiter
    import cpu_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel_port,
    output logic               bus_valid,
    output logic [3:0]         hold_cnt
);

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    arb_state_t         r_state;
    logic [SEL_W-1:0]   r_owner;
    logic [SEL_W-1:0]   r_ptr;
    logic [3:0]         r_hold;
    logic [NUM_REQ-1:0] r_gnt;

    arb_state_t         w_state_nxt;
    logic [SEL_W-1:0]   w_owner_nxt;
    logic [SEL_W-1:0]   w_ptr_nxt;
    logic [3:0]         w_hold_nxt;
    logic [NUM_REQ-1:0] w_gnt_nxt;
    logic               w_take;

    logic [NUM_REQ-1:0] w_others;
    logic [NUM_REQ-1:0] w_mask;
    logic [SEL_W-1:0]   w_pick;
    logic               w_any;

    // Candidates: everyone when idle, everyone except the owner when granted.
    assign w_others = req & ~(4'b0001 << r_owner);
    assign w_mask   = (r_state == IDLE) ? req : w_others;

    rr_pick4 u_pick (
        .i_mask (w_mask),
        .i_ptr  (r_ptr),
        .o_idx  (w_pick),
        .o_any  (w_any)
    );

    // Next-state: grant, hand-over, forced rotation, hold, or release.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold;
        w_take      = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_take = 1'b1;
                end
            end
            GRANT: begin
                if (!req[r_owner]) begin
                    if (w_any) begin
                        w_take = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_hold_nxt  = 4'd0;
                    end
                end else if ((r_hold == HOLD_LAST) && w_any) begin
                    w_take = 1'b1;
                end else if (r_hold != HOLD_LAST) begin
                    w_hold_nxt = r_hold + 4'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_take) begin
            w_state_nxt = GRANT;
            w_owner_nxt = w_pick;
            w_hold_nxt  = 4'd0;
            w_ptr_nxt   = w_pick + 2'd1;
        end

        w_gnt_nxt = (w_state_nxt == GRANT) ? (4'b0001 << w_owner_nxt) : 4'b0000;
    end

    // State registers with synchronous reset that overrides any grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_hold  <= '0;
            r_gnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= w_hold_nxt;
            r_gnt   <= w_gnt_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign sel_port  = r_owner;
    assign bus_valid = |r_gnt;
    assign hold_cnt  = r_hold;

endmodule
